handshake_tx64: RTL
===================

// Module: handshake_tx64
// PURPOSE
// - Transmit end of the 64-bit readyB/acceptedC shared-bus handshake, on the clkC domain.
// - Packs narrow upstream words into 64-bit beats.
// - Presents each beat on sharedBus64 with readyB held high until the receiver pulses acceptedC.
// - Sits between the upstream word source and the 64-bit receiver.
// PARAMETERS
// - WORD_W       16   upstream word width; must divide 64 (8, 16, 32 or 64)
// - TIMEOUT_CYC  255  SEND cycles without acceptedC before err_timeout is set; 0 disables it
// PORTS
// - clkC         in   1       clock; all logic on the rising edge
// - rst          in   1       asynchronous reset, active-low
// - word_in      in   WORD_W  upstream data word
// - word_valid   in   1       word_in is valid this cycle
// - word_ready   out  1       packer can take a word; transfer = word_valid & word_ready at an edge
// - flush        in   1       send the partial beat, zero-padded
// - acceptedC    in   1       receiver has latched sharedBus64 (one-cycle pulse)
// - readyB       out  1       sharedBus64 holds a valid beat
// - sharedBus64  out  64      beat data, registered
// - beats_sent   out  16      count of completed handshakes; wraps at 0xFFFF->0
// - err_timeout  out  1       sticky flag: TIMEOUT_CYC expired in SEND
// BEHAVIOUR
// - Reset (async, rst=0), applied immediately:
//   - readyB=0, sharedBus64=0, beats_sent=0, err_timeout=0.
//   - Packer is emptied and word_ready=1; FSM goes to IDLE.
// - Reset mid-operation drops partial and pending beats without a handshake.
// - Packer, N = 64/WORD_W lanes:
//   - The first accepted word goes to bits [WORD_W-1:0]; the next goes one lane higher.
//   - word_ready = !pk_full.
//   - The beat is full when lane N-1 is written at edge E.
// - flush:
//   - Sampled at an edge when at least one lane is filled: the beat is marked full, and unfilled lanes read 0.
//   - Ignored when the packer is empty.
//   - word_valid with flush in the same cycle: the word is packed first, then flush applies.
// - FSM, states in handshake_pkg (tx_state_t):
//   - IDLE: readyB=0.
//     - If pk_full: at the edge, sharedBus64 <= packed beat, packer empties, readyB=1, go to SEND.
//     - Latency: last word at edge E gives readyB high after edge E+1.
//   - SEND: readyB=1; sharedBus64 and readyB stay stable.
//     - acceptedC=1 at an edge: readyB <= 0, beats_sent += 1, go to GAP.
//   - GAP: readyB=0 for exactly one cycle, then go to IDLE.
//     - The gap lets the receiver return to idle before the next readyB.
// - The packer keeps accepting words during SEND and GAP. The next beat can fill while one is pending.
// - acceptedC is ignored outside SEND.
// - acceptedC held high across several cycles counts once, because the FSM leaves SEND.
// - Timeout: a counter runs in SEND and clears on leaving SEND.
//   - When it reaches TIMEOUT_CYC (and TIMEOUT_CYC != 0), err_timeout <= 1.
//   - The FSM stays in SEND; readyB stays high.
// - Widths: beats_sent is a modulo-2^16 increment. The timeout counter is $clog2(TIMEOUT_CYC+1) bits wide and saturates.
// STRUCTURE
// - handshake_pkg:
//   - BUS_W = 64
//   - typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GAP} tx_state_t
//   - the package is shared with the receiver-side RTL
// - Sub-module word_packer: lane index, pk_full, flush/zero-pad, word_ready. Instantiated once.
// - Top level: FSM, output register, beats_sent, timeout counter.
// TESTING
// 1. Packing and lane order
//    - Stimulus: words 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles; acceptedC pulsed 2 cycles after readyB rises.
//    - Response: sharedBus64 = 0x4444_3333_2222_1111; readyB high after edge E+1 of the last word; beats_sent = 1.
// 2. Flush with zero-pad
//    - Stimulus: 0xAAAA, then 0xBBBB together with flush.
//    - Response: sharedBus64 = 0x0000_0000_BBBB_AAAA; readyB = 1.
//    - Flush with the packer empty gives no readyB.
// 3. Back pressure
//    - Stimulus: 12 words streamed continuously; acceptedC withheld for 20 cycles.
//    - Response: word_ready = 0 once the second beat is full.
//    - Response: sharedBus64 and readyB stay stable while held.
//    - Response: after accepts, three beats in order; one readyB-low GAP cycle between beats.
// 4. Receiver pairing
//    - Stimulus: connect to the receiver device model; send 100 random beats.
//    - Response: every beat latched exactly once with no duplicate; beats_sent = 100.
// 5. Timeout
//    - Stimulus: TIMEOUT_CYC = 8; acceptedC never asserted.
//    - Response: err_timeout = 1 exactly 8 cycles into SEND; readyB stays 1.
//    - Response: a later accept still completes the handshake; err_timeout stays 1.
// 6. Reset mid-operation
//    - Stimulus: rst low during SEND with 2 lanes of the next beat filled.
//    - Response: readyB and sharedBus64 go to 0 immediately; word_ready = 1; beats_sent = 0.
//    - Response: after release, the next 4 words form a clean beat.

Source files
------------

// File: rtl/handshake_pkg.sv
// handshake_pkg: shared bus width and transmit FSM states for the readyB/acceptedC handshake
package handshake_pkg;
  localparam int BUS_W = 64;
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GAP} tx_state_t;
endpackage

// File: rtl/word_packer.sv
// word_packer: packs WORD_W-bit upstream words into 64-bit beats, lowest lane first, with zero-padded flush
module word_packer
  import handshake_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic              clkC,
  input  logic              rst,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic              flush,
  input  logic              pop,
  output logic              pk_full,
  output logic [BUS_W-1:0]  beat
);
  localparam int N = BUS_W / WORD_W;
  localparam logic [3:0] LAST = 4'(N - 1);
  logic [3:0] lane;
  logic push;
  assign word_ready = !pk_full;
  assign push = word_valid && word_ready;
  always_ff @(posedge clkC or negedge rst)
    if (!rst) begin
      beat <= '0;
      lane <= '0;
      pk_full <= 1'b0;
    end else if (pop) begin
      beat <= '0;
      lane <= '0;
      pk_full <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++)
        if (push && lane == 4'(i)) beat[i*WORD_W +: WORD_W] <= word_in;
      if (push) lane <= lane + 4'd1;
      if ((push && lane == LAST) || (flush && (push || lane != '0))) pk_full <= 1'b1;
    end
endmodule

// File: rtl/handshake_tx64.sv
// handshake_tx64: transmit end of the 64-bit readyB/acceptedC handshake with word packer, beat counter and timeout
module handshake_tx64
  import handshake_pkg::*;
#(
  parameter int WORD_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clkC,
  input  logic              rst,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic              flush,
  input  logic              acceptedC,
  output logic              readyB,
  output logic [BUS_W-1:0]  sharedBus64,
  output logic [15:0]       beats_sent,
  output logic              err_timeout
);
  localparam int TW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);
  tx_state_t state, state_nx;
  logic pk_full, pop, accept;
  logic [BUS_W-1:0] beat;
  logic [TW-1:0] to_cnt;
  word_packer #(.WORD_W(WORD_W)) u_packer (
    .clkC(clkC),
    .rst(rst),
    .word_in(word_in),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .flush(flush),
    .pop(pop),
    .pk_full(pk_full),
    .beat(beat)
  );
  assign pop = state == TX_IDLE && pk_full;
  assign accept = state == TX_SEND && acceptedC;
  assign readyB = state == TX_SEND;
  always_comb
    state_nx = pop ? TX_SEND : accept ? TX_GAP : state == TX_GAP ? TX_IDLE : state;
  always_ff @(posedge clkC or negedge rst)
    if (!rst) state <= TX_IDLE;
    else state <= state_nx;
  always_ff @(posedge clkC or negedge rst)
    if (!rst) begin
      sharedBus64 <= '0;
      beats_sent <= '0;
      to_cnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (pop) sharedBus64 <= beat;
      if (accept) beats_sent <= beats_sent + 16'd1;
      to_cnt <= state != TX_SEND ? '0 : to_cnt == TMAX ? TMAX : to_cnt + 1'b1;
      if (TIMEOUT_CYC != 0 && state == TX_SEND && !acceptedC && to_cnt == TMAX - 1'b1) err_timeout <= 1'b1;
    end
endmodule
